// File: rtl/lsu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_arbiter
// Description : Round-robin arbiter from NUM_LANES LSU lanes to one registered
//               data-memory command port, with fixed-latency load-tag return.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_arbiter #(
    parameter int NUM_LANES   = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_LANES-1:0]      lane_req_valid,
    input  logic [NUM_LANES-1:0]      lane_req_we,
    input  logic [NUM_LANES*32-1:0]   lane_req_addr,
    input  logic [NUM_LANES*32-1:0]   lane_req_wdata,
    output logic [NUM_LANES-1:0]      lane_gnt,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_ready,
    input  logic [31:0]               mem_rdata,
    output logic [NUM_LANES-1:0]      resp_valid,
    output logic [31:0]               resp_data
);

    localparam int                IDX_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W:0]    C_NUM_LANES = (IDX_W+1)'(NUM_LANES);
    localparam logic [IDX_W-1:0]  C_LAST_LANE = IDX_W'(NUM_LANES - 1);

    logic [31:0]                  w_lane_addr  [NUM_LANES];
    logic [31:0]                  w_lane_wdata [NUM_LANES];

    logic [IDX_W-1:0]             r_rr_ptr;
    logic [IDX_W-1:0]             r_cmd_lane;
    logic                         w_free;
    logic                         w_accept;
    logic                         w_found;
    logic                         w_grant;
    logic [IDX_W:0]               w_idx;
    logic [IDX_W-1:0]             w_sel;
    logic [IDX_W-1:0]             w_next_ptr;
    logic [NUM_LANES-1:0]         w_gnt;

    logic [MEM_LATENCY-1:0]       r_tag_vld;
    logic [MEM_LATENCY*IDX_W-1:0] r_tag_idx;
    logic [IDX_W-1:0]             w_tail_idx;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_unpack
            assign w_lane_addr[i]  = lane_req_addr[32*i +: 32];
            assign w_lane_wdata[i] = lane_req_wdata[32*i +: 32];
        end
    endgenerate

    // The register can take a new command whenever the held one leaves this cycle.
    assign w_free   = !mem_req || mem_ready;
    assign w_accept = mem_req && mem_ready;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
            if (w_idx >= C_NUM_LANES) begin
                w_idx = w_idx - C_NUM_LANES;
            end
            if (!w_found && lane_req_valid[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[IDX_W-1:0];
            end
        end
    end

    assign w_grant    = rst_n && w_free && w_found;
    assign w_next_ptr = (w_sel == C_LAST_LANE) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_gnt = '0;
        if (w_grant) begin
            w_gnt[w_sel] = 1'b1;
        end
    end

    assign lane_gnt = w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_cmd_lane <= '0;
            r_rr_ptr   <= '0;
        end else if (w_free) begin
            mem_req <= w_grant;
            if (w_grant) begin
                mem_we     <= lane_req_we[w_sel];
                mem_addr   <= w_lane_addr[w_sel];
                mem_wdata  <= w_lane_wdata[w_sel];
                r_cmd_lane <= w_sel;
                r_rr_ptr   <= w_next_ptr;
            end
        end
    end

    // Tag pipeline shifts every cycle; only accepted loads enter as valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_vld[0]           <= w_accept && !mem_we;
            r_tag_idx[IDX_W-1:0]   <= r_cmd_lane;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                r_tag_vld[s]                <= r_tag_vld[s-1];
                r_tag_idx[s*IDX_W +: IDX_W] <= r_tag_idx[(s-1)*IDX_W +: IDX_W];
            end
        end
    end

    assign w_tail_idx = r_tag_idx[(MEM_LATENCY-1)*IDX_W +: IDX_W];

    always_comb begin
        resp_valid = '0;
        if (r_tag_vld[MEM_LATENCY-1]) begin
            resp_valid[w_tail_idx] = 1'b1;
        end
    end

    assign resp_data = mem_rdata;

endmodule
`default_nettype wire
